// File: rtl/imem_boot_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_boot_loader_pkg
// Shared definitions for the instruction-memory boot loader: loader state
// encoding, default memory geometry and word/byte widths, plus a helper that
// drops a stream byte into its big-endian lane of a 32-bit word.
// -----------------------------------------------------------------------------
package imem_boot_loader_pkg;

    localparam int WORD_W          = 32;
    localparam int BYTE_W          = 8;
    localparam int IMEM_DEPTH_DEF  = 256;
    localparam int ADDR_W_DEF      = 8;
    localparam int RUN_CYCLES_DEF  = 30;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } loader_state_e;

    // Byte index 0 lands in [31:24], index 3 in [7:0]; other lanes are zero.
    function automatic logic [WORD_W-1:0] place_byte(input logic [BYTE_W-1:0] b,
                                                     input logic [1:0]        idx);
        return {b, 24'h000000} >> {idx, 3'b000};
    endfunction

endpackage

// File: rtl/imem_boot_loader_byte_packer.sv
// -----------------------------------------------------------------------------
// imem_boot_loader_byte_packer
// Assembles 4 stream bytes (MSB byte first) into a 32-bit word. The word and
// its valid strobe are presented combinationally in the cycle the completing
// byte is accepted, so the caller can register them straight into the memory
// write port. A last byte on index 0..2 completes the word early with zero
// padding and raises padded_o alongside word_valid_o.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   accept_i          a byte is accepted this cycle
//   data_i [7:0]      accepted byte
//   last_i            accepted byte is the final byte of the program
//   word_valid_o      a word completes this cycle
//   word_o [31:0]     completed (possibly padded) word
//   padded_o          completed word was short (zero padded)
// -----------------------------------------------------------------------------
module imem_boot_loader_byte_packer
    import imem_boot_loader_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              accept_i,
    input  logic [BYTE_W-1:0] data_i,
    input  logic              last_i,
    output logic              word_valid_o,
    output logic [WORD_W-1:0] word_o,
    output logic              padded_o
);

    logic [1:0]        idx_q, idx_d;
    logic [WORD_W-1:0] acc_q, acc_d;
    logic [WORD_W-1:0] word_cmb;
    logic              complete;

    always_comb begin
        // acc_q only holds earlier bytes; unfilled low lanes are already zero.
        word_cmb = acc_q | place_byte(data_i, idx_q);
        complete = accept_i & ((idx_q == 2'd3) | last_i);
        idx_d    = idx_q;
        acc_d    = acc_q;
        if (accept_i) begin
            if (complete) begin
                idx_d = 2'd0;
                acc_d = '0;
            end else begin
                idx_d = idx_q + 2'd1;
                acc_d = word_cmb;
            end
        end
    end

    assign word_valid_o = complete;
    assign word_o       = word_cmb;
    assign padded_o     = complete & (idx_q != 2'd3);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_q <= 2'd0;
            acc_q <= '0;
        end else begin
            idx_q <= idx_d;
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// -----------------------------------------------------------------------------
// imem_boot_loader
// Clears instruction memory, fills it from a byte stream, then releases the
// CPU and counts run cycles. Sequence: CLEAR (zero sweep of every address),
// LOAD (stream bytes packed into words), RUN (cpu_run_o high, cycle count),
// DONE (sticky, only reset leaves). All outputs are registered.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   s_valid_i/s_data_i/s_last_i/s_ready_o   byte stream handshake
//   imem_we_o/imem_addr_o/imem_wdata_o      instruction memory write port
//   cpu_run_o           CPU released from reset
//   done_o              RUN_CYCLES elapsed (sticky)
//   word_cnt_o          words written from the stream (saturates at depth)
//   err_o               sticky: short final word or overflow
// -----------------------------------------------------------------------------
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int IMEM_DEPTH = IMEM_DEPTH_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int RUN_CYCLES = RUN_CYCLES_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              s_valid_i,
    input  logic [BYTE_W-1:0] s_data_i,
    input  logic              s_last_i,
    output logic              s_ready_o,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [WORD_W-1:0] imem_wdata_o,
    output logic              cpu_run_o,
    output logic              done_o,
    output logic [ADDR_W:0]   word_cnt_o,
    output logic              err_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_DEPTH - 1);
    localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W+1)'(IMEM_DEPTH);
    localparam logic [31:0]       LAST_CYC  = 32'(RUN_CYCLES - 1);

    loader_state_e     state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              ready_q, ready_d;
    logic              run_q, run_d;
    logic              done_q, done_d;
    logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
    logic              err_q, err_d;
    logic [31:0]       cyc_q, cyc_d;

    logic              accept;
    logic              word_valid;
    logic [WORD_W-1:0] word;
    logic              padded;

    // s_ready_o is high only in LOAD, so accept cannot fire in other states.
    assign accept = s_valid_i & ready_q;

    imem_boot_loader_byte_packer u_packer (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .accept_i     (accept),
        .data_i       (s_data_i),
        .last_i       (s_last_i),
        .word_valid_o (word_valid),
        .word_o       (word),
        .padded_o     (padded)
    );

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        word_cnt_d = word_cnt_q;
        err_d      = err_q;
        cyc_d      = cyc_q;
        done_d     = done_q;

        case (state_q)
            ST_CLEAR: begin
                we_d       = 1'b1;
                addr_d     = clr_addr_q;
                wdata_d    = '0;
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == LAST_ADDR) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (word_valid) begin
                    if (word_cnt_q != FULL_CNT) begin
                        we_d       = 1'b1;
                        addr_d     = word_cnt_q[ADDR_W-1:0];
                        wdata_d    = word;
                        word_cnt_d = word_cnt_q + 1'b1;
                    end else begin
                        // Memory full: word dropped, stream still drained.
                        err_d = 1'b1;
                    end
                    if (padded) begin
                        err_d = 1'b1;
                    end
                end
                if (accept && s_last_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Counting starts once cpu_run_o is visible so that done_o
                // lands exactly RUN_CYCLES cycles after cpu_run_o rises.
                if (run_q) begin
                    cyc_d = cyc_q + 32'd1;
                    if ((RUN_CYCLES != 0) && (cyc_q == LAST_CYC)) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            default: begin
            end
        endcase

        ready_d = (state_d == ST_LOAD);
        // Follows state_q so the CPU is released the cycle after the final write.
        run_d   = (state_q == ST_RUN) || (state_q == ST_DONE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ready_q    <= 1'b0;
            run_q      <= 1'b0;
            done_q     <= 1'b0;
            word_cnt_q <= '0;
            err_q      <= 1'b0;
            cyc_q      <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ready_q    <= ready_d;
            run_q      <= run_d;
            done_q     <= done_d;
            word_cnt_q <= word_cnt_d;
            err_q      <= err_d;
            cyc_q      <= cyc_d;
        end
    end

    assign s_ready_o    = ready_q;
    assign imem_we_o    = we_q;
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;
    assign cpu_run_o    = run_q;
    assign done_o       = done_q;
    assign word_cnt_o   = word_cnt_q;
    assign err_o        = err_q;

endmodule
